// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: one shared memory port, one ALU,
// memory-ready handshake with optional bus-error timeout, retired-instruction counter.
module multicycle_controller #(
    parameter int TIMEOUT     = 255,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   adr_select,
    output logic                   IR_write,
    output logic                   PC_write,
    output logic                   reg_write,
    output logic [1:0]             ALU_src_A,
    output logic [1:0]             ALU_src_B,
    output logic [1:0]             ALU_op,
    output logic [1:0]             result_select,
    output logic                   instr_done,
    output logic                   illegal,
    output logic                   bus_error,
    output logic [COUNT_WIDTH-1:0] instret,
    output logic [3:0]             state
);

    typedef enum logic [4:0] {
        S_START    = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_MEMADR   = 5'd3,
        S_MEMREAD  = 5'd4,
        S_MEMWB    = 5'd5,
        S_MEMWRITE = 5'd6,
        S_EXECR    = 5'd7,
        S_EXECI    = 5'd8,
        S_ALUWB    = 5'd9,
        S_BRANCH   = 5'd10,
        S_JAL      = 5'd11,
        S_JALR     = 5'd12,
        S_LINK     = 5'd13,
        S_LUI      = 5'd14,
        S_AUIPC    = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_wait;
    logic              timeout_hit;
    logic              set_illegal;

    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000, 3'b101, 3'b111: branch_taken = z;
            3'b001, 3'b100, 3'b110: branch_taken = ~z;
            default:                branch_taken = 1'b0;
        endcase
    endfunction

    // Only the three memory-handshake states can stall; elsewhere mem_ready is ignored.
    assign mem_wait    = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                         && !mem_ready;
    assign timeout_hit = (TIMEOUT > 0) && mem_wait && (wait_cnt_q == WAIT_LIMIT);

    // TRAP has no 4-bit code of its own; it reads as 0 and is told apart by illegal/bus_error.
    assign state = (state_q == S_TRAP) ? 4'd0 : state_q[3:0];

    always_comb begin
        state_d       = state_q;
        set_illegal   = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        adr_select    = 1'b0;
        IR_write      = 1'b0;
        PC_write      = 1'b0;
        reg_write     = 1'b0;
        ALU_src_A     = 2'b00;
        ALU_src_B     = 2'b00;
        ALU_op        = 2'b00;
        result_select = 2'b00;
        instr_done    = 1'b0;

        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                mem_read      = 1'b1;
                ALU_src_B     = 2'b10;
                result_select = 2'b10;
                if (mem_ready) begin
                    IR_write = 1'b1;
                    PC_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b01;
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_AUIPC;
                    default: begin
                        state_d     = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALU_src_A = 2'b10;
                ALU_src_B = 2'b01;
                state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read   = 1'b1;
                adr_select = 1'b1;
                if (mem_ready)        state_d = S_MEMWB;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_MEMWB: begin
                result_select = 2'b01;
                reg_write     = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write  = 1'b1;
                adr_select = 1'b1;
                if (mem_ready)        state_d = S_FETCH;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_EXECR: begin
                ALU_src_A = 2'b10;
                ALU_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                ALU_src_A = 2'b10;
                ALU_src_B = 2'b01;
                ALU_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALU_src_A = 2'b10;
                ALU_op    = 2'b01;
                PC_write  = branch_taken(funct3, zero);
                state_d   = S_FETCH;
            end
            S_JAL: begin
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b10;
                PC_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                ALU_src_A     = 2'b10;
                ALU_src_B     = 2'b01;
                result_select = 2'b10;
                PC_write      = 1'b1;
                state_d       = S_LINK;
            end
            S_LINK: begin
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b10;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                ALU_src_A = 2'b11;
                ALU_src_B = 2'b01;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                ALU_src_A = 2'b01;
                ALU_src_B = 2'b01;
                state_d   = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_START;
        endcase

        // Retirement is any real entry into FETCH; the post-reset START->FETCH is not one.
        instr_done = (state_d == S_FETCH) && (state_q != S_START) && (state_q != S_FETCH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_START;
            wait_cnt_q <= '0;
            illegal    <= 1'b0;
            bus_error  <= 1'b0;
            instret    <= '0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal <= 1'b1;
            if (timeout_hit) bus_error <= 1'b1;
            if (instr_done)  instret <= instret + COUNT_WIDTH'(1);
            if ((TIMEOUT > 0) && mem_wait && (state_d == state_q))
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            else
                wait_cnt_q <= '0;
        end
    end

endmodule
